// File: rtl/prn_phase_detector_if.sv
// Sample/command bundle between the phase detector and its neighbours.
// The slave side is the detector; the master side feeds data and takes shift commands.
interface prn_phase_detector_if #(
   parameter int WIN_LEN = 64
);
   localparam int CW = $clog2(WIN_LEN + 1);

   logic          en;
   logic          din;
   logic          shift_right;
   logic          shift_left;
   logic          lock;
   logic [CW-1:0] prompt_cnt;

   modport master (
      output en,
      output din,
      input  shift_right,
      input  shift_left,
      input  lock,
      input  prompt_cnt
   );

   modport slave (
      input  en,
      input  din,
      output shift_right,
      output shift_left,
      output lock,
      output prompt_cnt
   );
endinterface

// File: rtl/prn_phase_detector.sv
// Early/late PRBS7 correlating phase detector steering a delay line.
// Optional lock detector enabled by defining PRN_PD_LOCK_DETECT_EN.
module prn_phase_detector #(
   parameter int         WIN_LEN    = 64,
   parameter int         THRESH     = 4,
   parameter int         SETTLE_WIN = 1,
   parameter int         LOCK_ERR   = 2,
   parameter logic [6:0] SEED       = 7'h7F
) (
   input logic                  clk,
   input logic                  rst,
   prn_phase_detector_if.slave  bus
);
   localparam int CW = $clog2(WIN_LEN + 1);
   localparam int WW = $clog2(WIN_LEN);
   localparam logic [WW-1:0]  WIN_LAST = WW'(WIN_LEN - 1);
   localparam logic signed [CW:0] THR = (CW+1)'(THRESH);
   localparam logic [1:0]     SET_LAST = 2'(SETTLE_WIN);

   if (SEED == 7'h00 || LOCK_ERR < 0 || LOCK_ERR > WIN_LEN) begin : g_bad_cfg
      $error("prn_phase_detector: bad SEED or LOCK_ERR");
   end

   typedef enum logic {ACCUM, SETTLE} state_t;

   state_t        state, state_nx;
   logic [1:0]    settle_cnt, settle_cnt_nx;
   logic [6:0]    lfsr;
   logic [2:0]    hist;
   logic [WW-1:0] win_cnt;
   logic [CW-1:0] e_acc, p_acc, l_acc;
   logic [CW-1:0] e_fin, p_fin, l_fin;
   logic signed [CW:0] diff;
   logic          win_end;
   logic          dec_right, dec_left;

   assign win_end = bus.en && (win_cnt == WIN_LAST);

   // Final counts include the current sample so nothing is lost at the boundary.
   assign e_fin = e_acc + CW'(bus.din == hist[0]);
   assign p_fin = p_acc + CW'(bus.din == hist[1]);
   assign l_fin = l_acc + CW'(bus.din == hist[2]);
   assign diff  = $signed({1'b0, e_fin}) - $signed({1'b0, l_fin});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr           <= SEED;
         hist           <= '0;
         win_cnt        <= '0;
         e_acc          <= '0;
         p_acc          <= '0;
         l_acc          <= '0;
         bus.prompt_cnt <= '0;
      end else if (bus.en) begin
         lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
         hist <= {hist[1:0], lfsr[6]};
         if (win_end) begin
            win_cnt        <= '0;
            e_acc          <= '0;
            p_acc          <= '0;
            l_acc          <= '0;
            bus.prompt_cnt <= p_fin;
         end else begin
            win_cnt <= win_cnt + 1'b1;
            e_acc   <= e_fin;
            p_acc   <= p_fin;
            l_acc   <= l_fin;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ACCUM;
         settle_cnt <= '0;
      end else begin
         state      <= state_nx;
         settle_cnt <= settle_cnt_nx;
      end
   end

   // The window that completes the settle period is itself still suppressed.
   always_comb begin
      state_nx      = state;
      settle_cnt_nx = settle_cnt;
      if (win_end) begin
         unique case (state)
            ACCUM: begin
               if ((dec_right || dec_left) && SETTLE_WIN != 0) begin
                  state_nx      = SETTLE;
                  settle_cnt_nx = '0;
               end
            end
            SETTLE: begin
               settle_cnt_nx = settle_cnt + 2'd1;
               if (settle_cnt_nx == SET_LAST)
                  state_nx = ACCUM;
            end
         endcase
      end
   end

   always_comb begin
      dec_right = 1'b0;
      dec_left  = 1'b0;
      if (win_end && state == ACCUM) begin
         if (diff >= THR)
            dec_right = 1'b1;
         else if (diff <= -THR)
            dec_left = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.shift_right <= 1'b0;
         bus.shift_left  <= 1'b0;
      end else begin
         bus.shift_right <= dec_right;
         bus.shift_left  <= dec_left;
      end
   end

`ifdef PRN_PD_LOCK_DETECT_EN
   logic prev_good, lock_q, good;

   assign good = p_fin >= CW'(WIN_LEN - LOCK_ERR);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_good <= 1'b0;
         lock_q    <= 1'b0;
      end else if (win_end) begin
         prev_good <= good;
         lock_q    <= good && prev_good;
      end
   end

   assign bus.lock = lock_q;
`else
   assign bus.lock = 1'b0;
`endif

endmodule

// File: tb/tb_prn_phase_detector.sv
// Directed bench for prn_phase_detector with a PRBS7 reference model.
// Lock expectations follow PRN_PD_LOCK_DETECT_EN.
module tb_prn_phase_detector;
   localparam int WL = 64;

`ifdef PRN_PD_LOCK_DETECT_EN
   localparam int LOCK_ON = 1;
`else
   localparam int LOCK_ON = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   prn_phase_detector_if #(.WIN_LEN(WL)) bus ();

   prn_phase_detector dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [6:0] m_lfsr;
   logic [2:0] m_hist;
   int edge_n, n_right, n_left, n_both;
   bit right_at [0:511];
   bit left_at  [0:511];

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_lfsr = 7'h7F;
      m_hist = 3'b000;
   endtask

   task automatic clr_stats();
      edge_n  = 0;
      n_right = 0;
      n_left  = 0;
      n_both  = 0;
      for (int i = 0; i < 512; i++) begin
         right_at[i] = 1'b0;
         left_at[i]  = 1'b0;
      end
   endtask

   // mode: 0 prompt-aligned, 1 early tap, 2 late tap, 3 toggling
   task automatic step(input bit en_v, input int mode);
      logic d;
      case (mode)
         0:       d = m_hist[1];
         1:       d = m_hist[0];
         2:       d = m_hist[2];
         default: d = edge_n[0];
      endcase
      bus.en  = en_v;
      bus.din = d;
      @(posedge clk);
      #1;
      edge_n++;
      if (rst && en_v) begin
         m_hist = {m_hist[1:0], m_lfsr[6]};
         m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
      end
      if (bus.shift_right) n_right++;
      if (bus.shift_left)  n_left++;
      if (bus.shift_right && bus.shift_left) n_both++;
      if (edge_n < 512) begin
         right_at[edge_n] = bus.shift_right;
         left_at[edge_n]  = bus.shift_left;
      end
   endtask

   task automatic do_reset(input int cyc);
      rst = 1'b0;
      m_reset();
      repeat (cyc) step(1'b1, 3);
      rst = 1'b1;
      clr_stats();
   endtask

   initial begin
      bus.en  = 1'b0;
      bus.din = 1'b0;
      m_reset();
      clr_stats();

      // reset held with activity on the inputs
      rst = 1'b0;
      repeat (12) step(1'b1, 3);
      check("rst_right", bus.shift_right, 0);
      check("rst_left", bus.shift_left, 0);
      check("rst_lock", bus.lock, 0);
      check("rst_pcnt", bus.prompt_cnt, 0);
      check("rst_pulses", n_right + n_left, 0);
      rst = 1'b1;
      clr_stats();

      // aligned data: full prompt agreement every window
      for (int w = 1; w <= 8; w++) begin
         repeat (WL) step(1'b1, 0);
         check($sformatf("al_pcnt_w%0d", w), bus.prompt_cnt, 64);
         check($sformatf("al_lock_w%0d", w), bus.lock,
               (LOCK_ON != 0 && w >= 2) ? 1 : 0);
      end
      check("al_no_pulse", n_right + n_left, 0);

      // early data: right at window 1, suppressed window 2, right window 3
      do_reset(3);
      repeat (4 * WL) step(1'b1, 1);
      check("early_w1", right_at[64], 1);
      check("early_w2", right_at[128], 0);
      check("early_w3", right_at[192], 1);
      check("early_nright", n_right, 2);
      check("early_nleft", n_left, 0);
      check("early_both", n_both, 0);

      // late data: left at window 1, weak prompt
      do_reset(3);
      repeat (WL) step(1'b1, 2);
      check("late_w1", left_at[64], 1);
      check("late_nright", n_right, 0);
      check("late_pcnt_lo", (bus.prompt_cnt < 62) ? 1 : 0, 1);
      check("late_lock", bus.lock, 0);
      check("late_both", n_both, 0);

      // lock rises on two good windows, falls on one bad window
      do_reset(3);
      repeat (2 * WL) step(1'b1, 0);
      check("lk_up", bus.lock, LOCK_ON);
      repeat (WL) step(1'b1, 2);
      check("lk_down", bus.lock, 0);
      check("lk_pcnt_lo", (bus.prompt_cnt < 62) ? 1 : 0, 1);

      // a 10-cycle stall delays the decision by exactly 10 cycles
      do_reset(3);
      repeat (20) step(1'b1, 1);
      repeat (10) step(1'b0, 1);
      repeat (60) step(1'b1, 1);
      check("stall_at74", right_at[74], 1);
      check("stall_nright", n_right, 1);

      // reset at sample 30 discards the partial window
      do_reset(3);
      repeat (30) step(1'b1, 1);
      check("abort_none", n_right + n_left, 0);
      rst = 1'b0;
      m_reset();
      repeat (3) step(1'b1, 1);
      rst = 1'b1;
      clr_stats();
      repeat (WL - 1) step(1'b1, 1);
      check("restart_early", n_right + n_left, 0);
      step(1'b1, 1);
      check("restart_at64", right_at[64], 1);

      // a pending pulse is cleared by asynchronous reset
      check("pend_high", bus.shift_right, 1);
      check("pend_pcnt_set", (bus.prompt_cnt != 0) ? 1 : 0, 1);
      rst = 1'b0;
      #1;
      check("pend_cleared", bus.shift_right, 0);
      check("pend_pcnt_clr", bus.prompt_cnt, 0);
      rst = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
